fpga_config_loader: RTL and testbench
=====================================

Name: fpga_config_loader

Overview:
- Drives the per-column configuration shift chains of the CLB tile array: `shift_enable[c]`, `shift_in_hard[c]` and `set_hard[c]`.
- Accepts the bitstream as a valid/ready word stream from the host/IO side and serializes each word onto one column chain at a time.
- After every column is filled, pulses `set_hard` so all config tiles latch their shifted contents.
- Sits between the chip-level bitstream port and the tile array, on the config clock domain.

Parameters:
- NUM_COLS, 2: number of tile columns, i.e. independent shift chains.
- WORD_W, 32: bitstream word width accepted per handshake.
- CHAIN_LEN, 1024: bits per column chain (NUM_ROWS x per-tile config bits). Must be a multiple of WORD_W; elaboration fails otherwise.
- WPC (localparam), CHAIN_LEN/WORD_W: words per column.
- NUM_WORDS (localparam), NUM_COLS*WPC: total words per bitstream.

Ports:
- clk, input, 1: config clock (fabric cclk).
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a load; sampled only in IDLE or DONE.
- s_data, input, WORD_W: bitstream word; bit 0 is shifted first.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: loader accepts s_data this cycle.
- shift_enable, output, NUM_COLS: per-column chain shift enable.
- shift_in_hard, output, NUM_COLS: per-column serial config bit.
- set_hard, output, NUM_COLS: per-column commit strobe.
- busy, output, 1: high from accepted start until DONE.
- done, output, 1: bitstream fully shifted and committed.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset asserted mid-load aborts immediately; the chains keep their partial contents and no set_hard is issued.
- All chain outputs are registered. A bit presented on `shift_in_hard[c]` with `shift_enable[c]`=1 is captured by the chain on the same clk edge that updates the next bit.
- States:
  - IDLE: waits for start=1, then goes to LOAD with col=0, word_cnt=0, busy=1.
  - LOAD: s_ready=1. On s_valid, s_data is captured into the shift register, bit_cnt=0, and the state goes to SHIFT.
  - SHIFT: each cycle `shift_enable[col]`=1 and `shift_in_hard[col]`=sreg[0]; sreg shifts right and bit_cnt increments. All other columns have enable=0 and data=0.
  - End of word (bit_cnt==WORD_W-1):
    - word_cnt increments; on reaching WPC it resets to 0 and col increments.
    - If this was word NUM_WORDS-1, go to COMMIT.
    - Otherwise s_ready=1 on this cycle. If s_valid, the next word is loaded and SHIFT continues with no bubble, on the new column if col advanced. If not s_valid, go to LOAD.
  - COMMIT: set_hard = all ones for exactly one cycle, shift_enable=0, then DONE.
  - DONE: done=1, busy=0, held until start=1, which restarts at LOAD (same as IDLE).
- start in LOAD/SHIFT/COMMIT is ignored.
- s_ready is never high in IDLE, COMMIT or DONE. Words offered there are not consumed.
- Ordering:
  - Column 0 is loaded fully before column 1.
  - Within a column, the first word shifted ends up at the far (top-row) end of the chain.
- Timing: a full load with a continuously valid source takes NUM_WORDS*WORD_W shift cycles + 1 LOAD cycle + 1 COMMIT cycle.
- Counters:
  - bit_cnt: clog2(WORD_W) bits.
  - word_cnt: clog2(WPC) bits, minimum 1.
  - col: clog2(NUM_COLS) bits, minimum 1.
  - None wraps past its terminal value.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LOAD, SHIFT, COMMIT, DONE);
  - the per-tile config size constants already used by the tile array (LUT/CB/SB/CLB sizes), so CHAIN_LEN is derived as NUM_ROWS*(CLB_TILE_COMB_CFG_SIZE+CLB_TILE_MEM_CFG_SIZE) at integration.
- One sub-module, `cfg_word_serializer`: WORD_W shift register + bit counter, exposing load, shift, bit_out and last_bit.

Test Plan (NUM_COLS=2, WORD_W=4, CHAIN_LEN=8, NUM_WORDS=4):
- Reset held, then released, with s_valid=1 → all outputs 0, s_ready=0 until start.
- start, then words 0x1,0x2,0x3,0x4 continuously valid:
  - shift_in_hard[0] sequence 1000 0100 with shift_enable=2'b01 for 8 cycles;
  - then shift_in_hard[1] sequence 1100 0010 with shift_enable=2'b10 for 8 cycles;
  - set_hard=2'b11 for 1 cycle, then done=1.
  - Total 18 cycles from start.
- Same load with s_valid low for 3 cycles after word 1 → shift_enable=0 during the gap, returns to LOAD, then resumes; final column contents are identical.
- rst_n pulsed low during word 2 → outputs 0 within the same cycle (async); no set_hard; a restart completes normally.
- start asserted during SHIFT → ignored.
- A 5th word offered after completion → not accepted (s_ready=0); done stays 1 until the next start.
- Scoreboard model of two 8-bit chains → after commit, chain contents equal the bitstream for random words over 100 loads.

Source files
------------

// File: rtl/fpga_config_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader_pkg
//  Description : Shared types and constants for the configuration loader.
//                Holds the loader FSM state encoding and the per-tile config
//                sizes used by the CLB tile array, so that the chain length
//                of a column can be derived from the number of tile rows.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpga_config_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DONE   = 3'd4
    } cfg_state_t;

    // Per-tile configuration sizes of the CLB tile array
    localparam int unsigned LUT_K                  = 4;
    localparam int unsigned LUT_CFG_SIZE           = 1 << LUT_K;
    localparam int unsigned LUTS_PER_CLB           = 4;
    localparam int unsigned CB_CFG_SIZE            = 16;
    localparam int unsigned SB_CFG_SIZE            = 16;
    localparam int unsigned CLB_TILE_COMB_CFG_SIZE = LUTS_PER_CLB * LUT_CFG_SIZE
                                                   + CB_CFG_SIZE + SB_CFG_SIZE;
    localparam int unsigned CLB_TILE_MEM_CFG_SIZE  = 32;

    // Length of one column shift chain for a given number of tile rows
    function automatic int unsigned chain_len(input int unsigned num_rows);
        return num_rows * (CLB_TILE_COMB_CFG_SIZE + CLB_TILE_MEM_CFG_SIZE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_config_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader_if
//  Description : Valid/ready bitstream word stream from the host/IO side.
//  Ports       : s_data  - bitstream word, bit 0 shifted first
//                s_valid - s_data valid (master -> slave)
//                s_ready - slave accepts s_data this cycle (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpga_config_loader_if #(
    parameter int WORD_W = 32
) ();
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/fpga_config_loader_cfg_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_word_serializer
//  Description : Word shift register and bit counter. bit_out is the serial
//                bit that the loader registers onto the chain output at the
//                next edge: bit 0 of data_in while loading, otherwise the next
//                not-yet-presented bit of the held word.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                load, data_in    - capture a new word (bit 0 presented first)
//                shift            - advance to the next bit of the word
//                bit_out          - serial bit for the next output cycle
//                last_bit         - the currently presented bit is bit WORD_W-1
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_word_serializer #(
    parameter int WORD_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load,
    input  wire logic              shift,
    input  wire logic [WORD_W-1:0] data_in,
    output logic                   bit_out,
    output logic                   last_bit
);
    localparam int                 c_CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WORD_W - 1);

    // Bit 0 goes straight to the output register on load, so only the
    // remaining WORD_W-1 bits are held here.
    logic [WORD_W-2:0]  r_rest;
    logic [c_CNT_W-1:0] r_bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rest    <= '0;
            r_bit_cnt <= '0;
        end else if (load) begin
            r_rest    <= data_in[WORD_W-1:1];
            r_bit_cnt <= '0;
        end else if (shift && (r_bit_cnt != c_CNT_LAST)) begin
            r_rest    <= r_rest >> 1;
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
        end
    end

    assign bit_out  = load ? data_in[0] : r_rest[0];
    assign last_bit = (r_bit_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_config_loader
//  Description : Serializes a valid/ready bitstream onto the per-column config
//                shift chains of the CLB tile array, column 0 first, then
//                pulses set_hard on every column to commit the contents.
//  Ports       : clk, rst_n     - config clock, async active-low reset
//                start          - begin a load (sampled in IDLE/DONE only)
//                s_if (slave)   - bitstream word stream
//                shift_enable   - per-column chain shift enable (registered)
//                shift_in_hard  - per-column serial config bit (registered)
//                set_hard       - per-column commit strobe (registered)
//                busy, done     - load in progress / load committed
//  Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader
    import fpga_config_loader_pkg::*;
#(
    parameter int NUM_COLS  = 2,
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start,
    fpga_config_loader_if.slave      s_if,
    output logic [NUM_COLS-1:0]      shift_enable,
    output logic [NUM_COLS-1:0]      shift_in_hard,
    output logic [NUM_COLS-1:0]      set_hard,
    output logic                     busy,
    output logic                     done
);
    localparam int WPC       = CHAIN_LEN / WORD_W;
    localparam int NUM_WORDS = NUM_COLS * WPC;
    localparam int c_WCNT_W  = (WPC > 1)      ? $clog2(WPC)      : 1;
    localparam int c_COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WPC - 1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] c_COL0_SEL  = NUM_COLS'(1);

    if (((CHAIN_LEN % WORD_W) != 0) || (WORD_W < 2) || (NUM_WORDS < 1)) begin : g_bad_params
        $error("fpga_config_loader: CHAIN_LEN must be a non-zero multiple of WORD_W (WORD_W >= 2)");
    end

    cfg_state_t          r_state;
    logic [c_COL_W-1:0]  r_col;
    logic [c_WCNT_W-1:0] r_word_cnt;
    logic [NUM_COLS-1:0] r_shift_en;
    logic [NUM_COLS-1:0] r_shift_in;
    logic [NUM_COLS-1:0] r_set_hard;
    logic                r_busy;
    logic                r_done;

    logic                w_bit;
    logic                w_last_bit;
    logic                w_word_end;
    logic                w_final_word;
    logic                w_col_wrap;
    logic                w_accept;
    logic                w_shift;
    logic [c_COL_W-1:0]  w_next_col;
    logic [NUM_COLS-1:0] w_load_sel;

    assign w_word_end   = (r_state == ST_SHIFT) && w_last_bit;
    assign w_col_wrap   = (r_word_cnt == c_WCNT_LAST);
    assign w_final_word = (r_col == c_COL_LAST) && w_col_wrap;
    assign w_shift      = (r_state == ST_SHIFT) && !w_last_bit;

    // Ready at the end of every word except the last, so a continuously
    // valid source keeps the chain shifting with no bubble.
    assign s_if.s_ready = (r_state == ST_LOAD) || (w_word_end && !w_final_word);
    assign w_accept     = s_if.s_ready && s_if.s_valid;

    // Column the next word lands on: LOAD keeps the current column, a
    // word-end load moves on once the column has received WPC words.
    assign w_next_col = (w_word_end && w_col_wrap) ? r_col + c_COL_W'(1) : r_col;
    assign w_load_sel = c_COL0_SEL << w_next_col;

    cfg_word_serializer #(
        .WORD_W   (WORD_W)
    ) u_serializer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_accept),
        .shift    (w_shift),
        .data_in  (s_if.s_data),
        .bit_out  (w_bit),
        .last_bit (w_last_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_word_cnt <= '0;
            r_shift_en <= '0;
            r_shift_in <= '0;
            r_set_hard <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_set_hard <= '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_col      <= '0;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_state    <= ST_SHIFT;
                        r_shift_en <= w_load_sel;
                        r_shift_in <= w_load_sel & {NUM_COLS{w_bit}};
                    end
                end
                ST_SHIFT: begin
                    if (!w_last_bit) begin
                        r_shift_in <= r_shift_en & {NUM_COLS{w_bit}};
                    end else if (w_final_word) begin
                        r_state    <= ST_COMMIT;
                        r_word_cnt <= '0;
                        r_shift_en <= '0;
                        r_shift_in <= '0;
                        r_set_hard <= '1;
                    end else begin
                        r_word_cnt <= w_col_wrap ? '0 : r_word_cnt + c_WCNT_W'(1);
                        r_col      <= w_next_col;
                        if (s_if.s_valid) begin
                            r_shift_en <= w_load_sel;
                            r_shift_in <= w_load_sel & {NUM_COLS{w_bit}};
                        end else begin
                            r_state    <= ST_LOAD;
                            r_shift_en <= '0;
                            r_shift_in <= '0;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign shift_enable  = r_shift_en;
    assign shift_in_hard = r_shift_in;
    assign set_hard      = r_set_hard;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fpga_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpga_config_loader
//  Description : Directed self-checking bench, NUM_COLS=2, WORD_W=4,
//                CHAIN_LEN=8. Models two 8-bit tile chains with commit latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpga_config_loader;
    localparam int c_BUDGET = 60;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] shift_enable;
    logic [1:0] shift_in_hard;
    logic [1:0] set_hard;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    fpga_config_loader_if #(.WORD_W(4)) s_if ();

    fpga_config_loader #(
        .NUM_COLS      (2),
        .WORD_W        (4),
        .CHAIN_LEN     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .s_if          (s_if),
        .shift_enable  (shift_enable),
        .shift_in_hard (shift_in_hard),
        .set_hard      (set_hard),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Tile array model: chains are not reset, first bit ends at bit 7
    logic [7:0] chain [2] = '{8'h00, 8'h00};
    logic [7:0] cfg   [2] = '{8'h00, 8'h00};
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (shift_enable[c]) chain[c] <= {chain[c][6:0], shift_in_hard[c]};
            if (set_hard[c])     cfg[c]   <= chain[c];
        end
    end

    logic [3:0] words [4];
    logic [1:0] en_tr [64];
    logic [1:0] in_tr [64];
    logic [1:0] sh_tr [64];
    logic       dn_tr [64];
    logic       bz_tr [64];

    // Drives one load from IDLE/DONE; trace index k = k-th edge counting the start edge as 1
    task automatic run_load(input int gap_at, input int gap_len, input int start_again_at,
                            input int abort_at, output int done_cyc);
        int   idx;
        int   gap_left;
        logic rdy;
        logic acc;
        idx = 0; gap_left = 0; done_cyc = -1;
        for (int k = 0; k < 64; k++) begin
            en_tr[k] = '0; in_tr[k] = '0; sh_tr[k] = '0; dn_tr[k] = 1'b0; bz_tr[k] = 1'b0;
        end
        start = 1'b1; s_if.s_valid = 1'b1; s_if.s_data = words[0];
        for (int cyc = 1; cyc <= c_BUDGET; cyc++) begin
            rdy = s_if.s_ready;
            acc = rdy && s_if.s_valid;
            @(posedge clk); #1;
            start = (cyc == start_again_at);
            if (acc) begin
                idx++;
                if (idx == gap_at) gap_left = gap_len;
            end else if (rdy && gap_left > 0) begin
                gap_left--;
            end
            s_if.s_valid = (idx < 4) && (gap_left == 0);
            s_if.s_data  = (idx < 4) ? words[idx] : 4'h0;
            en_tr[cyc] = shift_enable; in_tr[cyc] = shift_in_hard; sh_tr[cyc] = set_hard;
            dn_tr[cyc] = done; bz_tr[cyc] = busy;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        if (abort_at < 0 && done_cyc < 0) begin
            total++; bad++;
            $display("FAIL load_timeout: done not seen within %0d cycles", c_BUDGET);
        end
        start = 1'b0; s_if.s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; s_if.s_valid = 1'b1; s_if.s_data = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({shift_enable, shift_in_hard, set_hard, busy, done, s_if.s_ready} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 0", {shift_enable, shift_in_hard, set_hard, busy, done, s_if.s_ready});
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({shift_enable, set_hard, busy, done, s_if.s_ready} !== 7'b0) begin
            bad++;
            $display("FAIL idle_no_start: got %b required 0", {shift_enable, set_hard, busy, done, s_if.s_ready});
        end
        s_if.s_valid = 1'b0;
    endtask

    task automatic test_basic_load();
        int         dc;
        logic [7:0] seq0;
        logic [7:0] seq1;
        logic [1:0] exp_en;
        logic [1:0] exp_in;
        logic [1:0] exp_sh;
        seq0 = 8'b1000_0100;
        seq1 = 8'b1100_0010;
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h4;
        run_load(-1, 0, -1, -1, dc);
        total++;
        if (dc - 1 !== 18) begin
            bad++;
            $display("FAIL basic_latency: got %0d cycles required 18", dc - 1);
        end
        for (int k = 1; k <= 18; k++) begin
            exp_en = 2'b00; exp_in = 2'b00; exp_sh = 2'b00;
            if (k >= 2 && k <= 9)   begin exp_en = 2'b01; exp_in = {1'b0, seq0[9 - k]}; end
            if (k >= 10 && k <= 17) begin exp_en = 2'b10; exp_in = {seq1[17 - k], 1'b0}; end
            if (k == 18) exp_sh = 2'b11;
            total++;
            if ({en_tr[k], in_tr[k], sh_tr[k]} !== {exp_en, exp_in, exp_sh}) begin
                bad++;
                $display("FAIL basic_cycle%0d: en/in/set got %b/%b/%b required %b/%b/%b",
                         k, en_tr[k], in_tr[k], sh_tr[k], exp_en, exp_in, exp_sh);
            end
        end
        total++;
        if (bz_tr[1] !== 1'b1 || bz_tr[18] !== 1'b1 || bz_tr[19] !== 1'b0 || dn_tr[18] !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_done: busy1=%b busy18=%b busy19=%b done18=%b required 1 1 0 0",
                     bz_tr[1], bz_tr[18], bz_tr[19], dn_tr[18]);
        end
        total++;
        if (cfg[0] !== 8'h84 || cfg[1] !== 8'hC2) begin
            bad++;
            $display("FAIL basic_chains: got %h %h required 84 c2", cfg[0], cfg[1]);
        end
    endtask

    task automatic test_gap();
        int dc;
        int idle_cnt;
        int shift_cnt;
        cfg[0] = 8'h00; cfg[1] = 8'h00;
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h4;
        run_load(2, 3, -1, -1, dc);
        idle_cnt = 0; shift_cnt = 0;
        for (int k = 2; k <= 20; k++) begin
            if (en_tr[k] == 2'b00) idle_cnt++;
            else shift_cnt++;
        end
        total++;
        if (idle_cnt !== 3 || shift_cnt !== 16) begin
            bad++;
            $display("FAIL gap_shape: idle=%0d shift=%0d required 3 16", idle_cnt, shift_cnt);
        end
        total++;
        if (en_tr[10] !== 2'b00 || en_tr[12] !== 2'b00 || en_tr[13] !== 2'b10) begin
            bad++;
            $display("FAIL gap_position: en10=%b en12=%b en13=%b required 00 00 10", en_tr[10], en_tr[12], en_tr[13]);
        end
        total++;
        if (dc - 1 !== 21) begin
            bad++;
            $display("FAIL gap_latency: got %0d required 21", dc - 1);
        end
        total++;
        if (cfg[0] !== 8'h84 || cfg[1] !== 8'hC2) begin
            bad++;
            $display("FAIL gap_chains: got %h %h required 84 c2", cfg[0], cfg[1]);
        end
    endtask

    task automatic test_mid_reset();
        int         dc;
        logic [7:0] prev0;
        logic [7:0] prev1;
        prev0 = cfg[0]; prev1 = cfg[1];
        words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'hC; words[3] = 4'h3;
        run_load(-1, 0, -1, 11, dc);
        #1;
        total++;
        if ({shift_enable, shift_in_hard, set_hard, busy, done, s_if.s_ready} !== 9'b0) begin
            bad++;
            $display("FAIL async_reset: got %b required 0", {shift_enable, shift_in_hard, set_hard, busy, done, s_if.s_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (cfg[0] !== prev0 || cfg[1] !== prev1) begin
            bad++;
            $display("FAIL abort_no_commit: got %h %h required %h %h", cfg[0], cfg[1], prev0, prev1);
        end
        @(posedge clk); #1;
        run_load(-1, 0, -1, -1, dc);
        total++;
        if (cfg[0] !== 8'h5A || cfg[1] !== 8'h3C || dc - 1 !== 18) begin
            bad++;
            $display("FAIL restart_load: got %h %h lat=%0d required 5a 3c 18", cfg[0], cfg[1], dc - 1);
        end
    endtask

    task automatic test_start_in_shift();
        int dc;
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h4;
        run_load(-1, 0, 6, -1, dc);
        total++;
        if (dc - 1 !== 18 || bz_tr[7] !== 1'b1 || en_tr[7] !== 2'b01) begin
            bad++;
            $display("FAIL start_ignored: lat=%0d busy7=%b en7=%b required 18 1 01", dc - 1, bz_tr[7], en_tr[7]);
        end
        total++;
        if (cfg[0] !== 8'h84 || cfg[1] !== 8'hC2) begin
            bad++;
            $display("FAIL start_ignored_chains: got %h %h required 84 c2", cfg[0], cfg[1]);
        end
    endtask

    task automatic test_word_after_done();
        int dc;
        s_if.s_valid = 1'b1; s_if.s_data = 4'h5;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total++;
            if (s_if.s_ready !== 1'b0 || done !== 1'b1 || shift_enable !== 2'b00) begin
                bad++;
                $display("FAIL fifth_word: ready=%b done=%b en=%b required 0 1 00", s_if.s_ready, done, shift_enable);
            end
        end
        total++;
        if (cfg[0] !== 8'h84 || cfg[1] !== 8'hC2) begin
            bad++;
            $display("FAIL fifth_word_chains: got %h %h required 84 c2", cfg[0], cfg[1]);
        end
        words[0] = 4'hF; words[1] = 4'h0; words[2] = 4'h8; words[3] = 4'h1;
        run_load(-1, 0, -1, -1, dc);
        total++;
        if (dn_tr[1] !== 1'b0 || bz_tr[1] !== 1'b1) begin
            bad++;
            $display("FAIL done_clear_on_start: done=%b busy=%b required 0 1", dn_tr[1], bz_tr[1]);
        end
        // stream {1,8,0,F}: col0 bits 1111 0000, col1 bits 0001 1000
        total++;
        if (cfg[0] !== 8'hF0 || cfg[1] !== 8'h18) begin
            bad++;
            $display("FAIL done_restart_chains: got %h %h required f0 18", cfg[0], cfg[1]);
        end
    endtask

    task automatic test_random_loads();
        int          dc;
        logic [15:0] stream;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        for (int n = 0; n < 100; n++) begin
            for (int w = 0; w < 4; w++) words[w] = 4'($urandom_range(0, 15));
            stream = {words[3], words[2], words[1], words[0]};
            for (int k = 0; k < 8; k++) begin
                exp0[7 - k] = stream[k];
                exp1[7 - k] = stream[8 + k];
            end
            run_load(-1, 0, -1, -1, dc);
            total++;
            if (cfg[0] !== exp0 || cfg[1] !== exp1) begin
                bad++;
                $display("FAIL random_load%0d: got %h %h required %h %h", n, cfg[0], cfg[1], exp0, exp1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gap();
        test_mid_reset();
        test_start_in_shift();
        test_word_after_done();
        test_random_loads();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
